// File: rtl/fall_ctl_pkg.sv
// Shared types and helpers for the gravity-drop controller (fall_ctl).
package fall_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    BOUNCE = 2'd2,
    LANDED = 2'd3
  } state_e;

  // Landing line: the sprite's top edge when its bottom touches the floor.
  function automatic int floor_lim(input int floor_y, input int img_h);
    return floor_y - img_h;
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) return hi[31:0];
    if (s < lo) return lo[31:0];
    return s[31:0];
  endfunction

endpackage

// File: rtl/fall_ctl_tick_gen.sv
// Physics tick generator: one-cycle pulse every TICK_CYCLES clocks, restarted by clr.
module tick_gen #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = ($clog2(TICK_CYCLES) > 0) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fall_ctl.sv
// Gravity-drop controller: latches a launch point and integrates fixed-point gravity per tick.
// Optional bounce behaviour is enabled by defining FALL_CTL_BOUNCE_EN.
module fall_ctl
  import fall_ctl_pkg::*;
#(
  parameter int XW          = 12,
  parameter int YW          = 12,
  parameter int FLOOR_Y     = 600,
  parameter int IMG_H       = 64,
  parameter int TICK_CYCLES = 100000,
  parameter int FRAC        = 4,
  parameter int VW          = 16,
  parameter int GRAVITY     = 16,
  parameter int VMAX        = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] start_x,
  input  logic [YW-1:0] start_y,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          busy,
  output logic          finish
);

  localparam int AW = YW + FRAC + 1;
  // One spare bit above the wider operand keeps the signed sum exact.
  localparam int SW = ((VW > AW) ? VW : AW) + 1;
  localparam int FLOOR_LIM = floor_lim(FLOOR_Y, IMG_H);
  localparam logic [YW-1:0] FLIM_Y = YW'(FLOOR_LIM);
  localparam logic [AW-1:0] FLOOR_ACC = {1'b0, FLIM_Y, {FRAC{1'b0}}};
  localparam logic signed [VW-1:0] VMAX_V = VW'(VMAX);

  state_e                state_q, state_d;
  logic [XW-1:0]         xpos_q, xpos_d;
  logic [YW-1:0]         ypos_q, ypos_d;
  logic signed [VW-1:0]  vel_q, vel_d;
  logic [AW-1:0]         yacc_q, yacc_d;
  logic                  finish_q, finish_d;
  logic                  launch;
  logic                  tick;
  logic                  tick_clr;

  logic signed [VW-1:0]  vel_sum;
  logic signed [VW-1:0]  vel_n;
  logic signed [SW-1:0]  y_sum;
  logic [SW-1:0]         y_sat;
  logic [SW-1:0]         y_px;
  logic                  contact;

  assign tick_clr = !((state_q == FALL) || (state_q == BOUNCE));

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign vel_sum = VW'(sat_add(32'(vel_q), 32'(GRAVITY), VW));
  assign vel_n   = (vel_sum > VMAX_V) ? VMAX_V : vel_sum;
  assign y_sum   = $signed({{(SW - AW){1'b0}}, yacc_q}) + SW'(vel_n);
  // Upward overshoot past the top of the screen pins the accumulator at zero.
  assign y_sat   = y_sum[SW-1] ? '0 : y_sum;
  assign y_px    = y_sat >> FRAC;
  assign contact = (y_px >= SW'(FLOOR_LIM));

`ifdef FALL_CTL_BOUNCE_EN
  localparam logic signed [VW-1:0] GRAV_V = VW'(GRAVITY);
  logic signed [VW-1:0] vel_abs;
  assign vel_abs = vel_n[VW-1] ? -vel_n : vel_n;
`endif

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    vel_d    = vel_q;
    yacc_d   = yacc_q;
    finish_d = 1'b0;
    launch   = 1'b0;
    case (state_q)
      IDLE: begin
        xpos_d = start_x;
        ypos_d = start_y;
        launch = start && !abort;
      end
`ifdef FALL_CTL_BOUNCE_EN
      FALL, BOUNCE: begin
`else
      FALL: begin
`endif
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          vel_d  = vel_n;
          yacc_d = y_sat[AW-1:0];
          ypos_d = y_px[YW-1:0];
          if (contact) begin
            ypos_d = FLIM_Y;
            yacc_d = FLOOR_ACC;
`ifdef FALL_CTL_BOUNCE_EN
            if ((state_q == BOUNCE) && (vel_abs < GRAV_V)) begin
              vel_d    = '0;
              state_d  = LANDED;
              finish_d = 1'b1;
            end else begin
              vel_d   = -(vel_n >>> 1);
              state_d = BOUNCE;
            end
`else
            vel_d    = '0;
            state_d  = LANDED;
            finish_d = 1'b1;
`endif
          end
        end
      end
      LANDED: begin
        if (abort) state_d = IDLE;
        else       launch  = start;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      xpos_d = start_x;
      vel_d  = '0;
      if (start_y >= FLIM_Y) begin
        ypos_d   = FLIM_Y;
        yacc_d   = FLOOR_ACC;
        state_d  = LANDED;
        finish_d = 1'b1;
      end else begin
        ypos_d  = start_y;
        yacc_d  = {1'b0, start_y, {FRAC{1'b0}}};
        state_d = FALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      xpos_q   <= '0;
      ypos_q   <= '0;
      vel_q    <= '0;
      yacc_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      vel_q    <= vel_d;
      yacc_q   <= yacc_d;
      finish_q <= finish_d;
    end
  end

  assign xpos   = xpos_q;
  assign ypos   = ypos_q;
  assign busy   = (state_q == FALL) || (state_q == BOUNCE);
  assign finish = finish_q;

endmodule

// File: tb/tb_fall_ctl.sv
// Directed self-checking bench for fall_ctl (TICK_CYCLES=4, FLOOR_LIM=536), two VMAX settings.
module tb_fall_ctl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [11:0] start_x, start_y;
  logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic        busy_a, finish_a, busy_b, finish_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fall_ctl #(.TICK_CYCLES(4), .VMAX(1024)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_x(start_x), .start_y(start_y),
    .xpos(xpos_a), .ypos(ypos_a), .busy(busy_a), .finish(finish_a)
  );

  fall_ctl #(.TICK_CYCLES(4), .VMAX(64)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_x(start_x), .start_y(start_y),
    .xpos(xpos_b), .ypos(ypos_b), .busy(busy_b), .finish(finish_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_x = '0; start_y = '0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic launch(input int x, input int y);
    start_x = 12'(x); start_y = 12'(y); start = 1'b1;
    step(1);
    start = 1'b0; start_x = '0; start_y = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (xpos_a !== 12'd0) begin errors++; $display("FAIL reset_xpos: got %0d expected 0", xpos_a); end
    checks++; if (ypos_a !== 12'd0) begin errors++; $display("FAIL reset_ypos: got %0d expected 0", ypos_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (finish_b !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish_b); end
    launch(200, 100);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_prefall_busy: got %b expected 1", busy_a); end
    step(6);
    rst = 1'b1;
    step(1);
    checks++; if (xpos_a !== 12'd0) begin errors++; $display("FAIL midfall_rst_xpos: got %0d expected 0", xpos_a); end
    checks++; if (ypos_a !== 12'd0) begin errors++; $display("FAIL midfall_rst_ypos: got %0d expected 0", ypos_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midfall_rst_busy: got %b expected 0", busy_a); end
    checks++; if (finish_a !== 1'b0) begin errors++; $display("FAIL midfall_rst_finish: got %b expected 0", finish_a); end
    rst = 1'b0; start_x = 12'd77; start_y = 12'd33;
    step(1);
    checks++; if (xpos_a !== 12'd77 || ypos_a !== 12'd33) begin errors++; $display("FAIL idle_track: got %0d,%0d expected 77,33", xpos_a, ypos_a); end
    $display("test_reset: done");
  endtask

  task automatic test_drop();
    int prev;
    int expy;
    do_reset();
    launch(200, 100);
    prev = 100;
    for (int n = 1; n <= 29; n++) begin
      step(3);
      checks++; if (ypos_a !== 12'(prev)) begin errors++; $display("FAIL drop_hold n=%0d: got %0d expected %0d", n, ypos_a, prev); end
      step(1);
      expy = 100 + n * (n + 1) / 2;
      checks++; if (ypos_a !== 12'(expy)) begin errors++; $display("FAIL drop_ypos n=%0d: got %0d expected %0d", n, ypos_a, expy); end
      checks++; if (xpos_a !== 12'd200 || busy_a !== 1'b1 || finish_a !== 1'b0) begin errors++; $display("FAIL drop_state n=%0d: got x=%0d busy=%b fin=%b expected 200,1,0", n, xpos_a, busy_a, finish_a); end
      prev = expy;
    end
    step(4);
    checks++; if (ypos_a !== 12'd536) begin errors++; $display("FAIL drop_clamp: got %0d expected 536", ypos_a); end
    checks++; if (xpos_a !== 12'd200) begin errors++; $display("FAIL drop_land_xpos: got %0d expected 200", xpos_a); end
`ifdef FALL_CTL_BOUNCE_EN
    checks++; if (busy_a !== 1'b1 || finish_a !== 1'b0) begin errors++; $display("FAIL bounce_contact: got busy=%b fin=%b expected 1,0", busy_a, finish_a); end
    step(4);
    checks++; if (ypos_a !== 12'd522) begin errors++; $display("FAIL bounce_rebound: got %0d expected 522", ypos_a); end
    for (int i = 0; i < 3000 && finish_a !== 1'b1; i++) step(1);
    checks++; if (finish_a !== 1'b1) begin errors++; $display("FAIL bounce_finish: got %b expected 1 within budget", finish_a); end
    checks++; if (ypos_a !== 12'd536 || busy_a !== 1'b0) begin errors++; $display("FAIL bounce_rest: got y=%0d busy=%b expected 536,0", ypos_a, busy_a); end
`else
    checks++; if (busy_a !== 1'b0 || finish_a !== 1'b1) begin errors++; $display("FAIL drop_land: got busy=%b fin=%b expected 0,1", busy_a, finish_a); end
`endif
    step(1);
    checks++; if (finish_a !== 1'b0 || ypos_a !== 12'd536) begin errors++; $display("FAIL drop_after: got fin=%b y=%0d expected 0,536", finish_a, ypos_a); end
    $display("test_drop: done");
  endtask

  task automatic test_vmax();
    int exp_cap[6] = '{101, 103, 106, 110, 114, 118};
    do_reset();
    launch(10, 100);
    for (int i = 0; i < 6; i++) begin
      step(4);
      checks++; if (ypos_b !== 12'(exp_cap[i])) begin errors++; $display("FAIL vmax_ypos tick=%0d: got %0d expected %0d", i + 1, ypos_b, exp_cap[i]); end
    end
    $display("test_vmax: done");
  endtask

  task automatic test_abort();
    do_reset();
    launch(200, 100);
    step(16);
    checks++; if (ypos_a !== 12'd110) begin errors++; $display("FAIL abort_pre: got %0d expected 110", ypos_a); end
    step(3);
    abort = 1'b1; start = 1'b1; start_x = 12'd5; start_y = 12'd300;
    step(1);
    checks++; if (busy_a !== 1'b0 || finish_a !== 1'b0) begin errors++; $display("FAIL abort_exit: got busy=%b fin=%b expected 0,0", busy_a, finish_a); end
    checks++; if (ypos_a !== 12'd110) begin errors++; $display("FAIL abort_tick_discard: got %0d expected 110", ypos_a); end
    abort = 1'b0; start = 1'b0;
    step(1);
    checks++; if (ypos_a !== 12'd300 || xpos_a !== 12'd5) begin errors++; $display("FAIL abort_track: got %0d,%0d expected 5,300", xpos_a, ypos_a); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++; if (finish_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d: got fin=%b busy=%b expected 0,0", i, finish_a, busy_a); end
    end
    $display("test_abort: done");
  endtask

  task automatic test_direct_land();
    do_reset();
    launch(40, 550);
    checks++; if (ypos_a !== 12'd536 || xpos_a !== 12'd40) begin errors++; $display("FAIL direct_pos: got %0d,%0d expected 40,536", xpos_a, ypos_a); end
    checks++; if (finish_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL direct_fin: got fin=%b busy=%b expected 1,0", finish_a, busy_a); end
    step(1);
    checks++; if (finish_a !== 1'b0) begin errors++; $display("FAIL direct_pulse: got %b expected 0", finish_a); end
    step(8);
    checks++; if (ypos_a !== 12'd536 || busy_a !== 1'b0 || finish_a !== 1'b0) begin errors++; $display("FAIL direct_hold: got y=%0d busy=%b fin=%b expected 536,0,0", ypos_a, busy_a, finish_a); end
    launch(41, 536);
    checks++; if (finish_a !== 1'b1 || ypos_a !== 12'd536 || xpos_a !== 12'd41) begin errors++; $display("FAIL relaunch_edge: got fin=%b y=%0d x=%0d expected 1,536,41", finish_a, ypos_a, xpos_a); end
    step(1);
    launch(42, 535);
    checks++; if (busy_a !== 1'b1 || ypos_a !== 12'd535) begin errors++; $display("FAIL relaunch_fall: got busy=%b y=%0d expected 1,535", busy_a, ypos_a); end
    step(4);
    checks++; if (ypos_a !== 12'd536) begin errors++; $display("FAIL near_floor: got %0d expected 536", ypos_a); end
`ifdef FALL_CTL_BOUNCE_EN
    checks++; if (finish_a !== 1'b0) begin errors++; $display("FAIL near_floor_fin: got %b expected 0", finish_a); end
`else
    checks++; if (finish_a !== 1'b1) begin errors++; $display("FAIL near_floor_fin: got %b expected 1", finish_a); end
`endif
    $display("test_direct_land: done");
  endtask

  task automatic test_no_relatch();
    do_reset();
    launch(200, 100);
    step(2);
    start = 1'b1; start_x = 12'd50; start_y = 12'd20;
    step(1);
    start = 1'b0;
    checks++; if (xpos_a !== 12'd200 || ypos_a !== 12'd100 || busy_a !== 1'b1) begin errors++; $display("FAIL no_relatch: got x=%0d y=%0d busy=%b expected 200,100,1", xpos_a, ypos_a, busy_a); end
    step(1);
    checks++; if (ypos_a !== 12'd101 || xpos_a !== 12'd200) begin errors++; $display("FAIL no_relatch_tick: got x=%0d y=%0d expected 200,101", xpos_a, ypos_a); end
    $display("test_no_relatch: done");
  endtask

  initial begin
    test_reset();
    test_drop();
    test_vmax();
    test_abort();
    test_direct_land();
    test_no_relatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
